// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the instruction-fetch queue.
package mips_pkg;

    localparam logic [31:0] MIPS_NOP = 32'h0;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} ifq_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry synchronous FIFO of fetched {pc, instr} entries with flush.
module ifq_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  ifq_entry_t    i_din,
    output ifq_entry_t    o_dout,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    ifq_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointer and occupancy tracking; flush empties the queue by snapping the read pointer to the write pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Entry storage; contents are only observed once counted, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner, imem req/ack sequencer and decode-facing queue; IFQ_BYPASS_EN adds an ack-to-decode bypass.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifq_state_t    r_state;
    ifq_state_t    w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_drop_pc;
    logic          w_fire;
    logic          w_byp;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    ifq_entry_t    w_head;
    ifq_entry_t    w_out;

    assign w_fire = (r_state == WAIT) && imem_ack && !redirect_valid;

`ifdef IFQ_BYPASS_EN
    assign w_byp = w_fire && w_empty;
    assign w_out = w_byp ? {r_fetch_pc, imem_rdata} : w_head;
`else
    assign w_byp = 1'b0;
    assign w_out = w_head;
`endif

    // A bypassed word accepted by decode in the ack cycle never enters the queue.
    assign w_push      = w_fire && !(w_byp && dec_ready);
    assign w_pop       = !w_empty && dec_ready && !redirect_valid;
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    assign imem_req     = (r_state != IDLE);
    assign imem_addr    = (r_state == DROP) ? r_drop_pc : r_fetch_pc;
    assign dec_valid    = !w_empty || w_byp;
    assign dec_instr    = dec_valid ? w_out.instr : MIPS_NOP;
    assign dec_pc       = dec_valid ? w_out.pc : 32'h0;
    assign dec_pc_plus4 = dec_pc + 32'd4;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   ({r_fetch_pc, imem_rdata}),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Fetch state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next fetch state: redirects win; an interrupted read is drained in DROP before refetching.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!redirect_valid && !w_full) w_state_nxt = WAIT;
            WAIT:    if (redirect_valid) w_state_nxt = imem_ack ? IDLE : DROP;
                     else if (imem_ack) w_state_nxt = (w_count_nxt < CW'(DEPTH)) ? WAIT : IDLE;
            DROP:    if (imem_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fetch PC advances per accepted word; drop PC keeps the abandoned address stable on the bus.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fetch_pc <= RESET_PC;
            r_drop_pc  <= RESET_PC;
        end else begin
            if (redirect_valid) r_fetch_pc <= redirect_pc;
            else if (w_fire)    r_fetch_pc <= r_fetch_pc + 32'd4;
            if (r_state == WAIT && redirect_valid && !imem_ack) r_drop_pc <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed cycle-table and corner-case sequences for ifetch_queue.
module tb_ifetch_queue;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        val;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl [40];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {~pc[15:0], pc[15:0]};
    endfunction

    function automatic vec_t v(input logic rst_n, input logic ack, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic req, input logic [31:0] addr, input logic val,
                               input logic [31:0] pc);
        vec_t r;
        r.rst_n = rst_n; r.ack = ack; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
        r.req = req; r.addr = addr; r.val = val; r.pc = pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    logic [31:0] got_pc [$];
    logic [31:0] got_ins [$];
    logic [31:0] got_p4 [$];

    initial begin
        // rst_n ack rv rpc rdy | req addr val pc   (inputs applied for one cycle, outputs checked before the edge)
        tbl[0]  = v(1, 0, 0, 0,      1, 0, 32'h0,   0, 32'h0);
        tbl[1]  = v(1, 1, 0, 0,      1, 1, 32'h0,   0, 32'h0);
        tbl[2]  = v(1, 1, 0, 0,      1, 1, 32'h4,   1, 32'h0);
        tbl[3]  = v(1, 1, 0, 0,      1, 1, 32'h8,   1, 32'h4);
        tbl[4]  = v(1, 1, 0, 0,      1, 1, 32'hc,   1, 32'h8);
        tbl[5]  = v(1, 0, 0, 0,      1, 1, 32'h10,  1, 32'hc);
        tbl[6]  = v(1, 0, 0, 0,      0, 1, 32'h10,  0, 32'h0);
        tbl[7]  = v(1, 1, 0, 0,      0, 1, 32'h10,  0, 32'h0);
        tbl[8]  = v(1, 1, 0, 0,      0, 1, 32'h14,  1, 32'h10);
        tbl[9]  = v(1, 1, 0, 0,      0, 1, 32'h18,  1, 32'h10);
        tbl[10] = v(1, 1, 0, 0,      0, 1, 32'h1c,  1, 32'h10);
        tbl[11] = v(1, 0, 0, 0,      0, 0, 32'h20,  1, 32'h10);
        tbl[12] = v(1, 1, 0, 0,      0, 0, 32'h20,  1, 32'h10);
        tbl[13] = v(1, 0, 0, 0,      1, 0, 32'h20,  1, 32'h10);
        tbl[14] = v(1, 0, 0, 0,      1, 0, 32'h20,  1, 32'h14);
        tbl[15] = v(1, 0, 0, 0,      0, 1, 32'h20,  1, 32'h18);
        tbl[16] = v(1, 1, 1, 32'h40, 1, 1, 32'h20,  1, 32'h18);
        tbl[17] = v(1, 0, 0, 0,      1, 0, 32'h40,  0, 32'h0);
        tbl[18] = v(1, 0, 0, 0,      1, 1, 32'h40,  0, 32'h0);
        tbl[19] = v(1, 1, 0, 0,      1, 1, 32'h40,  0, 32'h0);
        tbl[20] = v(1, 0, 0, 0,      0, 1, 32'h44,  1, 32'h40);
        tbl[21] = v(1, 0, 1, 32'h100,0, 1, 32'h44,  1, 32'h40);
        tbl[22] = v(1, 0, 0, 0,      1, 1, 32'h44,  0, 32'h0);
        tbl[23] = v(1, 1, 0, 0,      1, 1, 32'h44,  0, 32'h0);
        tbl[24] = v(1, 0, 0, 0,      1, 0, 32'h100, 0, 32'h0);
        tbl[25] = v(1, 1, 0, 0,      0, 1, 32'h100, 0, 32'h0);
        tbl[26] = v(1, 0, 0, 0,      0, 1, 32'h104, 1, 32'h100);
        tbl[27] = v(1, 0, 1, 32'h200,0, 1, 32'h104, 1, 32'h100);
        tbl[28] = v(1, 0, 1, 32'h300,0, 1, 32'h104, 0, 32'h0);
        tbl[29] = v(1, 1, 0, 0,      0, 1, 32'h104, 0, 32'h0);
        tbl[30] = v(1, 0, 0, 0,      0, 0, 32'h300, 0, 32'h0);
        tbl[31] = v(1, 1, 0, 0,      0, 1, 32'h300, 0, 32'h0);
        tbl[32] = v(1, 1, 0, 0,      0, 1, 32'h304, 1, 32'h300);
        tbl[33] = v(0, 0, 0, 0,      0, 0, 32'h0,   0, 32'h0);
        tbl[34] = v(0, 0, 0, 0,      1, 0, 32'h0,   0, 32'h0);
        tbl[35] = v(1, 0, 0, 0,      1, 0, 32'h0,   0, 32'h0);
        tbl[36] = v(1, 0, 0, 0,      1, 1, 32'h0,   0, 32'h0);
        tbl[37] = v(1, 1, 0, 0,      1, 1, 32'h0,   0, 32'h0);
        tbl[38] = v(1, 0, 0, 0,      1, 1, 32'h4,   1, 32'h0);
        tbl[39] = v(1, 0, 0, 0,      1, 1, 32'h4,   0, 32'h0);

        RST_N = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            RST_N          = tbl[i].rst_n;
            imem_ack       = tbl[i].ack;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            dec_ready      = tbl[i].rdy;
            #1;
            imem_rdata = instr_of(imem_addr);
            #1;
            chk($sformatf("row%0d imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("row%0d dec_valid", i), {31'h0, dec_valid}, {31'h0, tbl[i].val});
            if (tbl[i].val || !tbl[i].rst_n) begin
                chk($sformatf("row%0d dec_pc", i), dec_pc, tbl[i].pc);
                chk($sformatf("row%0d dec_instr", i), dec_instr, tbl[i].val ? instr_of(tbl[i].pc) : 32'h0);
                chk($sformatf("row%0d dec_pc_plus4", i), dec_pc_plus4, tbl[i].pc + 32'd4);
            end
        end

        // Memory answering on the 3rd request cycle; redirect to 0x100 while the read of 0x8 is pending.
        do_reset();
        begin
            int  wcnt;
            bit  redirected;
            wcnt = 0;
            redirected = 1'b0;
            for (int c = 0; c < 60 && got_pc.size() < 3; c++) begin
                #1;
                imem_ack       = imem_req && (wcnt == 2);
                redirect_valid = imem_req && (imem_addr == 32'h8) && (wcnt == 1) && !redirected;
                redirect_pc    = 32'h100;
                imem_rdata     = instr_of(imem_addr);
                #1;
                if (dec_valid && dec_ready && !redirect_valid) begin
                    got_pc.push_back(dec_pc);
                    got_ins.push_back(dec_instr);
                    got_p4.push_back(dec_pc_plus4);
                end
                if (redirect_valid) redirected = 1'b1;
                wcnt = (!imem_req || imem_ack) ? 0 : wcnt + 1;
                @(negedge CLK);
            end
        end
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        chk("latency3 delivered count", got_pc.size(), 3);
        if (got_pc.size() == 3) begin
            chk("latency3 pc0", got_pc[0], 32'h0);
            chk("latency3 pc1", got_pc[1], 32'h4);
            chk("latency3 pc2 after redirect", got_pc[2], 32'h100);
            chk("latency3 instr2", got_ins[2], instr_of(32'h100));
            chk("latency3 plus4_2", got_p4[2], 32'h104);
        end

        // Ack with an empty queue and decode ready: bypass delivers in the ack cycle, otherwise one cycle later.
        do_reset();
        begin
            int guard;
            guard = 0;
            #1;
            while (!imem_req && guard < 5) begin
                @(negedge CLK);
                #1;
                guard++;
            end
            chk("bypass setup imem_req", {31'h0, imem_req}, 32'h1);
            imem_ack   = 1'b1;
            dec_ready  = 1'b1;
            imem_rdata = instr_of(imem_addr);
            #1;
`ifdef IFQ_BYPASS_EN
            chk("bypass ack-cycle dec_valid", {31'h0, dec_valid}, 32'h1);
            chk("bypass ack-cycle dec_pc", dec_pc, 32'h0);
            chk("bypass ack-cycle dec_instr", dec_instr, instr_of(32'h0));
            @(negedge CLK);
            imem_ack = 1'b0;
            #1;
            chk("bypass consumed, queue empty", {31'h0, dec_valid}, 32'h0);
`else
            chk("no-bypass ack-cycle dec_valid", {31'h0, dec_valid}, 32'h0);
            @(negedge CLK);
            imem_ack = 1'b0;
            #1;
            chk("no-bypass next-cycle dec_valid", {31'h0, dec_valid}, 32'h1);
            chk("no-bypass next-cycle dec_instr", dec_instr, instr_of(32'h0));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
